// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute/memory/writeback sequencer for a MIPS-like datapath
//   Optional feature macro CU_MEM_TIMEOUT_EN: MEMORY aborts to HALT after MEM_TIMEOUT cycles
//   without mem_ready and raises a sticky mem_error (port and parameter exist only then).
//   Ports: clock, reset (async active-low); instr_data/flagBRANCH/mem_ready in;
//   pc, State, flagALU, OPCODE, FUNCT, shamt, immediate, rs_addr, rt_addr, reg_waddr,
//   reg_write, wb_sel, mem_req, mem_we, halted (, mem_error) out.
module control_unit #(
  parameter int PC_BITS = 10
`ifdef CU_MEM_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 16
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        instr_data,
  input  logic               flagBRANCH,
  input  logic               mem_ready,
  output logic [PC_BITS-1:0] pc,
  output logic [2:0]         State,
  output logic [1:0]         flagALU,
  output logic [5:0]         OPCODE,
  output logic [5:0]         FUNCT,
  output logic [4:0]         shamt,
  output logic [31:0]        immediate,
  output logic [4:0]         rs_addr,
  output logic [4:0]         rt_addr,
  output logic [4:0]         reg_waddr,
  output logic               reg_write,
  output logic               wb_sel,
  output logic               mem_req,
  output logic               mem_we,
`ifdef CU_MEM_TIMEOUT_EN
  output logic               mem_error,
`endif
  output logic               halted
);
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;
  state_t state, state_d;
  logic [31:0] ir;
  logic [4:0] rd;
  logic [5:0] op_ir, funct_d;
  logic [PC_BITS-1:0] pc_d, pc_inc;
  logic is_lw, is_sw, is_br, timeout;
  assign op_ir = ir[31:26];
  // Immediate ALU ops 8..11 select FUNCT 1/3/5/7; LW/SW compute their address with FUNCT 1.
  assign funct_d = (op_ir[5:2] == 4'd2) ? {3'b000, op_ir[1:0], 1'b1} :
                   (op_ir == 6'd12 || op_ir == 6'd13) ? 6'd1 : ir[5:0];
  assign is_lw = OPCODE == 6'd12;
  assign is_sw = OPCODE == 6'd13;
  assign is_br = OPCODE == 6'd6 || OPCODE == 6'd7;
  assign pc_inc = pc + PC_BITS'(1);
  assign State = state;
  assign halted = state == HALT;
  assign reg_waddr = (OPCODE == 6'd0) ? rd : rt_addr;
`ifdef CU_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign timeout = state == MEMORY && !mem_ready && cnt == CW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt <= '0;
      mem_error <= 1'b0;
    end else begin
      cnt <= (state == MEMORY) ? cnt + CW'(1) : '0;
      if (timeout) mem_error <= 1'b1;
    end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state;
    pc_d = pc;
    flagALU = 2'd0;
    reg_write = 1'b0;
    wb_sel = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    unique case (state)
      FETCH: state_d = DECODE;
      DECODE: begin
        state_d = (op_ir == 6'd2) ? FETCH : (op_ir == 6'd3) ? HALT : EXECUTE;
        pc_d = (op_ir == 6'd2) ? ir[PC_BITS-1:0] : pc;
      end
      EXECUTE: begin
        flagALU = (OPCODE == 6'd0 || (OPCODE >= 6'd8 && OPCODE <= 6'd13)) ? 2'd1 :
                  (OPCODE[5:2] == 4'd1) ? 2'd2 : 2'd0;
        state_d = (is_lw || is_sw) ? MEMORY : WRITEBACK;
      end
      MEMORY: begin
        mem_req = 1'b1;
        mem_we = is_sw;
        state_d = timeout ? HALT : !mem_ready ? MEMORY : is_sw ? FETCH : WRITEBACK;
        pc_d = (mem_ready && is_sw) ? pc_inc : pc;
      end
      WRITEBACK: begin
        reg_write = OPCODE inside {6'd0, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12};
        wb_sel = is_lw;
        pc_d = (is_br && flagBRANCH) ? pc_inc + immediate[PC_BITS-1:0] : pc_inc;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
      OPCODE <= '0;
      FUNCT <= '0;
      shamt <= '0;
      immediate <= '0;
      rs_addr <= '0;
      rt_addr <= '0;
      rd <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      if (state == FETCH) ir <= instr_data;
      if (state == DECODE) begin
        OPCODE <= op_ir;
        FUNCT <= funct_d;
        shamt <= ir[10:6];
        immediate <= {{16{ir[15]}}, ir[15:0]};
        rs_addr <= ir[25:21];
        rt_addr <= ir[20:16];
        rd <= ir[15:11];
      end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized and directed self-checking bench for control_unit
module tb_control_unit;
  localparam int PCB = 10;
  localparam int NPC = 1 << PCB;
  logic clock = 1'b0, reset = 1'b0;
  logic [31:0] instr_data;
  logic flagBRANCH = 1'b0, mem_ready = 1'b0;
  logic [PCB-1:0] pc;
  logic [2:0] State;
  logic [1:0] flagALU;
  logic [5:0] OPCODE, FUNCT;
  logic [4:0] shamt, rs_addr, rt_addr, reg_waddr;
  logic [31:0] immediate;
  logic reg_write, wb_sel, mem_req, mem_we, halted;
`ifdef CU_MEM_TIMEOUT_EN
  logic mem_error;
`endif
  logic [31:0] imem [NPC];
  typedef struct packed {
    logic [2:0] st;
    logic [1:0] alu;
    logic [5:0] funct;
    logic rw;
    logic [4:0] wa;
    logic wbs;
    logic mreq;
    logic mwe;
  } obs_t;
  obs_t trace[$];
  int vectors = 0, miscompares = 0;

  control_unit #(.PC_BITS(PCB)) dut (
    .clock(clock), .reset(reset), .instr_data(instr_data), .flagBRANCH(flagBRANCH),
    .mem_ready(mem_ready), .pc(pc), .State(State), .flagALU(flagALU), .OPCODE(OPCODE),
    .FUNCT(FUNCT), .shamt(shamt), .immediate(immediate), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .reg_waddr(reg_waddr), .reg_write(reg_write), .wb_sel(wb_sel), .mem_req(mem_req),
`ifdef CU_MEM_TIMEOUT_EN
    .mem_error(mem_error),
`endif
    .mem_we(mem_we), .halted(halted)
  );

  always #5 clock = ~clock;
  assign instr_data = imem[pc];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Drives one instruction from FETCH until the DUT is back in FETCH or in HALT (64-cycle bound),
  // recording the outputs of every cycle; mem_ready is random noise outside MEMORY.
  task automatic run_instr(input logic [31:0] ins, input logic br, input int delay);
    int mcnt = 0;
    obs_t o;
    imem[pc] = ins;
    trace.delete();
    flagBRANCH = br;
    for (int i = 0; i < 64; i++) begin
      mem_ready = (State == 3'd3) ? (mcnt == delay) : 1'($urandom_range(0, 1));
      #1;
      o = {State, flagALU, FUNCT, reg_write, reg_waddr, wb_sel, mem_req, mem_we};
      trace.push_back(o);
      if (State == 3'd3) mcnt++;
      tick();
      if (State == 3'd0 || State == 3'd5) break;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    run_instr({6'd8, 5'd7, 5'd9, 16'hFFF0}, 1'b0, 0);
    #2 reset = 1'b0;
    #1;
    vectors++; if (State !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", State); end
    vectors++; if (pc !== '0) begin miscompares++; $display("FAIL rst_pc: got %0h want 0", pc); end
    vectors++; if ({flagALU, reg_write, mem_req, mem_we, halted} !== 6'd0) begin
      miscompares++; $display("FAIL rst_strobes: got %b want 000000", {flagALU, reg_write, mem_req, mem_we, halted}); end
    vectors++; if ({OPCODE, FUNCT, shamt, immediate, rs_addr, rt_addr, reg_waddr} !== '0) begin
      miscompares++; $display("FAIL rst_fields: got op %0h f %0h imm %0h rs %0d rt %0d wa %0d want all 0",
        OPCODE, FUNCT, immediate, rs_addr, rt_addr, reg_waddr); end
`ifdef CU_MEM_TIMEOUT_EN
    vectors++; if (mem_error !== 1'b0) begin miscompares++; $display("FAIL rst_mem_error: got %b want 0", mem_error); end
`endif
    tick();
    reset = 1'b1;
    #1;
    vectors++; if (State !== 3'd0 || pc !== '0) begin
      miscompares++; $display("FAIL rst_release: got state %0d pc %0h want 0 0", State, pc); end
  endtask

  task automatic test_add();
    int es[4] = '{0, 1, 2, 4};
    run_instr(32'h00221800, 1'b0, 0);
    vectors++; if (trace.size() != 4) begin miscompares++; $display("FAIL add_len: got %0d want 4", trace.size()); end
    foreach (es[i]) if (i < trace.size()) begin
      vectors++; if (trace[i].st !== 3'(es[i])) begin miscompares++; $display("FAIL add_state%0d: got %0d want %0d", i, trace[i].st, es[i]); end
    end
    if (trace.size() == 4) begin
      vectors++; if (trace[2].alu !== 2'd1 || trace[2].funct !== 6'd0) begin
        miscompares++; $display("FAIL add_exec: got alu %0d funct %0d want 1 0", trace[2].alu, trace[2].funct); end
      vectors++; if (trace[3].rw !== 1'b1 || trace[3].wa !== 5'd3 || trace[3].wbs !== 1'b0) begin
        miscompares++; $display("FAIL add_wb: got rw %b wa %0d wbs %b want 1 3 0", trace[3].rw, trace[3].wa, trace[3].wbs); end
    end
    vectors++; if (pc !== 10'd1) begin miscompares++; $display("FAIL add_pc: got %0d want 1", pc); end
  endtask

  task automatic test_branch();
    run_instr({6'd2, 26'd5}, 1'b0, 0);
    vectors++; if (pc !== 10'd5 || trace.size() != 2) begin
      miscompares++; $display("FAIL jump5: got pc %0d len %0d want 5 2", pc, trace.size()); end
    run_instr({6'd6, 5'd3, 5'd4, 16'd4}, 1'b1, 0);
    vectors++; if (pc !== 10'd10) begin miscompares++; $display("FAIL beq_taken: got %0d want 10", pc); end
    vectors++; if (trace.size() != 4 || trace[2].alu !== 2'd2 || trace[3].rw !== 1'b0) begin
      miscompares++; $display("FAIL beq_ctrl: got len %0d alu %0d rw %b want 4 2 0", trace.size(), trace[2].alu, trace[3].rw); end
    run_instr({6'd2, 26'd5}, 1'b0, 0);
    run_instr({6'd6, 5'd3, 5'd4, 16'd4}, 1'b0, 0);
    vectors++; if (pc !== 10'd6) begin miscompares++; $display("FAIL beq_not_taken: got %0d want 6", pc); end
    run_instr({6'd7, 10'd0, 16'hFFF9}, 1'b1, 0);
    vectors++; if (pc !== 10'd0) begin miscompares++; $display("FAIL bne_back: got %0d want 0", pc); end
    run_instr({6'd2, 26'h3FE}, 1'b0, 0);
    run_instr({6'd6, 10'd0, 16'd2}, 1'b1, 0);
    vectors++; if (pc !== 10'd1) begin miscompares++; $display("FAIL beq_wrap: got %0d want 1", pc); end
  endtask

  task automatic test_lw_sw();
    int nreq = 0;
    int es[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    run_instr({6'd12, 5'd2, 5'd9, 16'h0020}, 1'b0, 3);
    foreach (trace[i]) if (trace[i].mreq) nreq++;
    vectors++; if (nreq != 4) begin miscompares++; $display("FAIL lw_mreq_cycles: got %0d want 4", nreq); end
    vectors++; if (trace.size() != 8) begin miscompares++; $display("FAIL lw_len: got %0d want 8", trace.size()); end
    foreach (es[i]) if (i < trace.size()) begin
      vectors++; if (trace[i].st !== 3'(es[i])) begin miscompares++; $display("FAIL lw_state%0d: got %0d want %0d", i, trace[i].st, es[i]); end
    end
    if (trace.size() == 8) begin
      vectors++; if (trace[2].alu !== 2'd1 || trace[2].funct !== 6'd1 || trace[3].mwe !== 1'b0) begin
        miscompares++; $display("FAIL lw_exec: got alu %0d funct %0d we %b want 1 1 0", trace[2].alu, trace[2].funct, trace[3].mwe); end
      vectors++; if (trace[7].wbs !== 1'b1 || trace[7].rw !== 1'b1 || trace[7].wa !== 5'd9) begin
        miscompares++; $display("FAIL lw_wb: got wbs %b rw %b wa %0d want 1 1 9", trace[7].wbs, trace[7].rw, trace[7].wa); end
    end
    vectors++; if (pc !== 10'd2) begin miscompares++; $display("FAIL lw_pc: got %0d want 2", pc); end
    run_instr({6'd13, 5'd2, 5'd9, 16'h0004}, 1'b0, 0);
    vectors++; if (trace.size() != 4 || trace[3].mreq !== 1'b1 || trace[3].mwe !== 1'b1) begin
      miscompares++; $display("FAIL sw_mem: got len %0d req %b we %b want 4 1 1", trace.size(), trace[3].mreq, trace[3].mwe); end
    vectors++; if (pc !== 10'd3 || State !== 3'd0) begin
      miscompares++; $display("FAIL sw_done: got pc %0d state %0d want 3 0", pc, State); end
  endtask

  task automatic test_jump_wrap();
    run_instr({6'd2, 26'h3FF}, 1'b0, 0);
    vectors++; if (pc !== 10'h3FF) begin miscompares++; $display("FAIL jump_3ff: got %0h want 3ff", pc); end
    run_instr({6'd1, 26'h3FFFFFF}, 1'b1, 0);
    vectors++; if (trace.size() != 4 || trace[2].st !== 3'd2 || trace[2].alu !== 2'd0 || trace[3].rw !== 1'b0) begin
      miscompares++; $display("FAIL nop_ctrl: got len %0d st %0d alu %0d rw %b want 4 2 0 0", trace.size(), trace[2].st, trace[2].alu, trace[3].rw); end
    vectors++; if (pc !== 10'd0) begin miscompares++; $display("FAIL nop_wrap: got %0h want 0", pc); end
  endtask

  task automatic test_halt();
    run_instr({6'd2, 26'h2A}, 1'b0, 0);
    run_instr({6'd3, 26'h155}, 1'b0, 0);
    vectors++; if (trace.size() != 2 || State !== 3'd5 || halted !== 1'b1) begin
      miscompares++; $display("FAIL halt_enter: got len %0d state %0d halted %b want 2 5 1", trace.size(), State, halted); end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      flagBRANCH = 1'b1;
      tick();
      vectors++; if (State !== 3'd5 || {mem_req, mem_we, reg_write, flagALU} !== 5'd0 || pc !== 10'h2A) begin
        miscompares++; $display("FAIL halt_hold%0d: got state %0d strobes %b pc %0h want 5 00000 2a",
          i, State, {mem_req, mem_we, reg_write, flagALU}, pc); end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_mem_wait();
    int nreq = 0;
    pulse_reset();
    run_instr({6'd13, 5'd1, 5'd2, 16'd0}, 1'b0, 1000);
    foreach (trace[i]) if (trace[i].mreq) nreq++;
`ifdef CU_MEM_TIMEOUT_EN
    vectors++; if (nreq != 16) begin miscompares++; $display("FAIL tmo_cycles: got %0d want 16", nreq); end
    vectors++; if (State !== 3'd5 || halted !== 1'b1) begin
      miscompares++; $display("FAIL tmo_halt: got state %0d halted %b want 5 1", State, halted); end
    vectors++; if (mem_error !== 1'b1 || mem_req !== 1'b0) begin
      miscompares++; $display("FAIL tmo_error: got err %b req %b want 1 0", mem_error, mem_req); end
    tick();
    tick();
    vectors++; if (mem_error !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b want 1", mem_error); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (mem_error !== 1'b0 || State !== 3'd0) begin
      miscompares++; $display("FAIL tmo_reset: got err %b state %0d want 0 0", mem_error, State); end
    tick();
    reset = 1'b1;
`else
    vectors++; if (nreq != 61) begin miscompares++; $display("FAIL wait_cycles: got %0d want 61", nreq); end
    vectors++; if (State !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1 || pc !== '0) begin
      miscompares++; $display("FAIL wait_hold: got state %0d req %b we %b pc %0h want 3 1 1 0", State, mem_req, mem_we, pc); end
`endif
  endtask

  task automatic test_reset_mid_memory();
    pulse_reset();
    imem[0] = {6'd13, 5'd3, 5'd4, 16'd8};
    flagBRANCH = 1'b0;
    tick();
    tick();
    tick();
    vectors++; if (State !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      miscompares++; $display("FAIL mid_mem_enter: got state %0d req %b we %b want 3 1 1", State, mem_req, mem_we); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++; $display("FAIL mid_mem_drop: got req %b we %b want 0 0", mem_req, mem_we); end
    vectors++; if (State !== 3'd0 || pc !== '0) begin
      miscompares++; $display("FAIL mid_mem_state: got state %0d pc %0h want 0 0", State, pc); end
    imem[0] = 32'h00221800;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
        miscompares++; $display("FAIL mid_mem_retry%0d: got req %b we %b want 0 0", i, mem_req, mem_we); end
    end
    tick();
    tick();
  endtask

  // Instruction-level reference: each instruction's state walk, control strobes and next pc
  // follow from its opcode alone.
  task automatic test_random();
    int ops[15] = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 20, 63};
    int mpc = 0;
    pulse_reset();
    for (int n = 0; n < 150; n++) begin
      int op, delay, imm, npc, e_alu, e_funct, e_wa;
      logic [31:0] r, ins;
      logic br, e_rw;
      int es[$];
      op = ops[$urandom_range(0, 14)];
      r = $urandom();
      ins = {6'(op), r[25:0]};
      br = 1'($urandom_range(0, 1));
      delay = $urandom_range(0, 3);
      imm = int'($signed(ins[15:0]));
      es = '{0, 1};
      if (op != 2) es.push_back(2);
      if (op == 12 || op == 13) for (int k = 0; k <= delay; k++) es.push_back(3);
      if (op != 2 && op != 13) es.push_back(4);
      e_alu = (op == 0 || (op >= 8 && op <= 13)) ? 1 : (op >= 4 && op <= 7) ? 2 : 0;
      e_funct = (op == 0) ? int'(ins[5:0]) : (op >= 8 && op <= 11) ? (op - 8) * 2 + 1 : 1;
      e_rw = op inside {0, 4, 5, 8, 9, 10, 11, 12};
      e_wa = (op == 0) ? int'(ins[15:11]) : int'(ins[20:16]);
      npc = (op == 2) ? int'(ins[PCB-1:0]) :
            ((op == 6 || op == 7) && br) ? ((mpc + 1 + imm) % NPC + NPC) % NPC : (mpc + 1) % NPC;
      vectors++; if (pc !== PCB'(mpc) || State !== 3'd0) begin
        miscompares++; $display("FAIL rnd%0d_start: got pc %0h state %0d want %0h 0", n, pc, State, mpc); end
      run_instr(ins, br, delay);
      vectors++; if (trace.size() != es.size()) begin
        miscompares++; $display("FAIL rnd%0d_len op %0d: got %0d want %0d", n, op, trace.size(), es.size()); end
      for (int i = 0; i < es.size() && i < trace.size(); i++) begin
        vectors++; if (trace[i].st !== 3'(es[i])) begin
          miscompares++; $display("FAIL rnd%0d_state%0d op %0d: got %0d want %0d", n, i, op, trace[i].st, es[i]); end
        vectors++; if (trace[i].alu !== 2'((es[i] == 2) ? e_alu : 0)) begin
          miscompares++; $display("FAIL rnd%0d_alu%0d op %0d: got %0d want %0d", n, i, op, trace[i].alu, (es[i] == 2) ? e_alu : 0); end
        if (es[i] == 2 && e_alu == 1) begin
          vectors++; if (trace[i].funct !== 6'(e_funct)) begin
            miscompares++; $display("FAIL rnd%0d_funct op %0d: got %0d want %0d", n, op, trace[i].funct, e_funct); end
        end
        vectors++; if (trace[i].rw !== ((es[i] == 4) ? e_rw : 1'b0) || trace[i].mreq !== (es[i] == 3)) begin
          miscompares++; $display("FAIL rnd%0d_strobe%0d op %0d: got rw %b req %b want %b %b",
            n, i, op, trace[i].rw, trace[i].mreq, (es[i] == 4) ? e_rw : 1'b0, es[i] == 3); end
        if (es[i] == 3) begin
          vectors++; if (trace[i].mwe !== (op == 13)) begin
            miscompares++; $display("FAIL rnd%0d_we op %0d: got %b want %b", n, op, trace[i].mwe, op == 13); end
        end
        if (es[i] == 4) begin
          vectors++; if (trace[i].wbs !== (op == 12) || (e_rw && trace[i].wa !== 5'(e_wa))) begin
            miscompares++; $display("FAIL rnd%0d_wb op %0d: got wbs %b wa %0d want %b %0d", n, op, trace[i].wbs, trace[i].wa, op == 12, e_wa); end
        end
      end
      vectors++; if (pc !== PCB'(npc)) begin
        miscompares++; $display("FAIL rnd%0d_pc op %0d br %b: got %0h want %0h", n, op, br, pc, npc); end
      mpc = npc;
    end
  endtask

  initial begin
    foreach (imem[i]) imem[i] = '0;
    tick();
    tick();
    reset = 1'b1;
    test_reset();
    test_add();
    test_branch();
    test_lw_sw();
    test_jump_wrap();
    test_halt();
    test_mem_wait();
    test_reset_mid_memory();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter PC_BITS, 10, program-counter width (word addresses).
REQ-002 Parameter MEM_TIMEOUT, 16, cycles allowed for mem_ready before abort (CU_MEM_TIMEOUT_EN only).
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 instr_data  in  32  instruction word at pc, valid combinationally during FETCH.
REQ-006 flagBRANCH  in  1  ALU branch-taken flag, valid the cycle after EXECUTE.
REQ-007 mem_ready  in  1  data-memory completion strobe.
REQ-008 pc  out  PC_BITS  instruction address.
REQ-009 State  out  3  FSM state code to ALU.
REQ-010 flagALU  out  2  ALU class: 0 idle, 1 FUNCT-op, 2 OPCODE-op.
REQ-011 OPCODE, FUNCT  out  6 each  decoded fields to ALU.
REQ-012 shamt  out  5; immediate  out  32  sign-extended instr[15:0].
REQ-013 rs_addr, rt_addr, reg_waddr  out  5 each  register-file addresses.
REQ-014 reg_write  out  1; wb_sel  out  1  (0 ALU RDvalue, 1 memory read data).
REQ-015 mem_req, mem_we  out  1 each; halted  out  1; mem_error  out  1 (CU_MEM_TIMEOUT_EN only).

Function
REQ-016 Fields: OPCODE=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], FUNCT=[5:0], jump target=[PC_BITS-1:0].
REQ-017 FSM codes SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5; State output equals the current code.
REQ-018 FETCH: IR captures instr_data; next DECODE.
REQ-019 DECODE: fields registered from IR; opcode 2 (JUMP) loads pc=target, next FETCH; opcode 3 (HALT) next HALT; else next EXECUTE.
REQ-020 EXECUTE, one cycle: opcode 0 -> flagALU=1, FUNCT=IR[5:0]; opcodes 8/9/10/11 -> flagALU=1, FUNCT=1/3/5/7; opcodes 12 (LW)/13 (SW) -> flagALU=1, FUNCT=1; opcodes 4-7 -> flagALU=2; flagALU SHALL be 0 in every other state.
REQ-021 From EXECUTE: LW/SW -> MEMORY; all others -> WRITEBACK.
REQ-022 MEMORY: mem_req=1 (mem_we=1 for SW) held until the cycle mem_ready=1; then LW -> WRITEBACK, SW -> FETCH with pc+1.
REQ-023 WRITEBACK, one cycle: reg_write=1 for opcodes 0, 4, 5, 8-12; reg_waddr=rd for opcode 0, rt otherwise; wb_sel=1 only for LW.
REQ-024 WRITEBACK for opcodes 6/7: pc = pc+1+immediate[PC_BITS-1:0] if flagBRANCH=1, else pc+1; all others pc+1; next FETCH.
REQ-025 PC arithmetic SHALL wrap modulo 2^PC_BITS.
REQ-026 Undefined opcodes SHALL execute as NOP: DECODE -> EXECUTE (flagALU=0) -> WRITEBACK (reg_write=0) -> pc+1.
REQ-027 HALT is absorbing until reset; halted=1, all strobes 0.
REQ-028 mem_ready outside MEMORY SHALL be ignored.

Reset
REQ-029 reset low SHALL immediately force FETCH, pc=0, IR=0, flagALU=0, reg_write=0, mem_req=0, mem_we=0, halted=0, mem_error=0, all field outputs 0.
REQ-030 Reset during MEMORY SHALL drop mem_req in the same instant with no write retried.
REQ-031 First FETCH occurs on the first posedge after reset deasserts.

Configuration
REQ-032 Macro CU_MEM_TIMEOUT_EN defined: cycle counter runs in MEMORY; MEM_TIMEOUT cycles without mem_ready -> mem_req=0, mem_error=1 (sticky), next HALT.
REQ-033 Macro CU_MEM_TIMEOUT_EN undefined: no counter, no mem_error port, MEMORY waits indefinitely.

Verification
REQ-034 Reset, instr 0x00221800 (ADD rd3,rs1,rt2) at pc 0 -> State 0,1,2,4; flagALU=1, FUNCT=0 in EXECUTE; reg_write=1, reg_waddr=3 in WRITEBACK; pc=1.
REQ-035 BEQ (opcode 6, imm=+4) at pc 5, flagBRANCH=1 -> pc=10; repeat with flagBRANCH=0 -> pc=6.
REQ-036 LW with mem_ready delayed 3 cycles -> mem_req high exactly 4 MEMORY cycles; WRITEBACK wb_sel=1, reg_write=1.
REQ-037 JUMP target 0x3FF with PC_BITS=10, then NOP at 0x3FF -> pc wraps to 0.
REQ-038 CU_MEM_TIMEOUT_EN, SW with mem_ready held 0 -> after 16 MEMORY cycles mem_error=1, State=5, halted=1; reset low mid-MEMORY -> mem_req=0 asynchronously, pc=0.
